// File: rtl/cache_mem_arbiter.sv
// ============================================================================
//  Module      : cache_mem_arbiter
//  Description : Shares one memory port between I-cache fills, D-cache fills
//                and D-cache write-through stores.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_mem_arbiter #(
    parameter int MEM_LATENCY = 4,
    parameter int BLOCK_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic [15:0] d_addr,
    input  logic        d_wr,
    input  logic [15:0] d_wr_addr,
    input  logic [15:0] d_wr_data,
    input  logic [15:0] mem_data_out,
    input  logic        mem_data_valid,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic [15:0] fill_data,
    output logic [2:0]  fill_word,
    output logic        i_fill_valid,
    output logic        d_fill_valid,
    output logic        i_done,
    output logic        d_done,
    output logic        wr_ack,
    output logic        busy
);

    localparam logic [2:0]  c_last_word = 3'(BLOCK_WORDS - 1);
    localparam logic [15:0] c_base_mask = 16'hFFF0;

    // The 3-bit word counters only cover an 8-word block.
    generate
        if (MEM_LATENCY < 1 || BLOCK_WORDS != 8) begin : g_param_check
            $error("cache_mem_arbiter: unsupported MEM_LATENCY/BLOCK_WORDS");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_FILL_I = 2'd2,
        ST_FILL_D = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_base;
    logic [2:0]  r_issue_cnt;
    logic [2:0]  r_recv_cnt;
    logic        r_issue_done;

    logic        w_filling;
    logic        w_issuing;
    logic        w_recv;
    logic        w_last;

    assign w_filling = (r_state == ST_FILL_I) || (r_state == ST_FILL_D);
    assign w_issuing = w_filling && !r_issue_done;
    assign w_recv    = w_filling && mem_data_valid;
    assign w_last    = w_recv && (r_recv_cnt == c_last_word);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_base       <= 16'h0000;
            r_issue_cnt  <= 3'd0;
            r_recv_cnt   <= 3'd0;
            r_issue_done <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE) begin
                r_issue_cnt  <= 3'd0;
                r_recv_cnt   <= 3'd0;
                r_issue_done <= 1'b0;
                if (!d_wr && d_req) begin
                    r_base <= d_addr & c_base_mask;
                end else if (!d_wr && i_req) begin
                    r_base <= i_addr & c_base_mask;
                end
            end else if (w_filling) begin
                // Counter parks on the last word; the flag ends the issue phase.
                if (w_issuing) begin
                    if (r_issue_cnt == c_last_word) begin
                        r_issue_done <= 1'b1;
                    end else begin
                        r_issue_cnt <= r_issue_cnt + 3'd1;
                    end
                end
                if (w_recv) begin
                    r_recv_cnt <= r_recv_cnt + 3'd1;
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (d_wr) begin
                    w_next_state = ST_WRITE;
                end else if (d_req) begin
                    w_next_state = ST_FILL_D;
                end else if (i_req) begin
                    w_next_state = ST_FILL_I;
                end
            end
            ST_WRITE: w_next_state = ST_IDLE;
            ST_FILL_I,
            ST_FILL_D: begin
                if (w_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = 16'h0000;
        mem_data_in  = 16'h0000;
        fill_data    = 16'h0000;
        fill_word    = 3'd0;
        i_fill_valid = 1'b0;
        d_fill_valid = 1'b0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        wr_ack       = 1'b0;
        busy         = (r_state != ST_IDLE);

        if (r_state == ST_WRITE) begin
            mem_en      = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = d_wr_addr;
            mem_data_in = d_wr_data;
            wr_ack      = 1'b1;
        end

        if (w_issuing) begin
            mem_en   = 1'b1;
            mem_addr = r_base + {12'h000, r_issue_cnt, 1'b0};
        end

        if (w_recv) begin
            fill_data    = mem_data_out;
            fill_word    = r_recv_cnt;
            i_fill_valid = (r_state == ST_FILL_I);
            d_fill_valid = (r_state == ST_FILL_D);
            i_done       = w_last && (r_state == ST_FILL_I);
            d_done       = w_last && (r_state == ST_FILL_D);
        end
    end

endmodule

`default_nettype wire
